// File: rtl/regfile_operand_stage_pkg.sv
// Shared definitions for the LEGv8 operand issue stage: widths, the
// hard-wired zero register and the ALU function-select encodings.
package regfile_operand_stage_pkg;

    localparam int DATA_W   = 64;
    localparam int NREGS    = 32;
    localparam int IDX_W    = 5;
    localparam int ZERO_REG = 31;
    localparam int IMM_W    = 12;
    localparam int FS_W     = 5;

    localparam logic [IDX_W-1:0] ZERO_IDX = IDX_W'(ZERO_REG);

    // ALU operation lives in FS[4:2]; FS[1] inverts A, FS[0] inverts B.
    typedef enum logic [2:0] {
        FS_AND = 3'b000,
        FS_OR  = 3'b001,
        FS_ADD = 3'b010,
        FS_XOR = 3'b011,
        FS_LSL = 3'b100,
        FS_LSR = 3'b101
    } fs_op_e;

    localparam int FS_INV_A_BIT = 1;
    localparam int FS_INV_B_BIT = 0;

    // Immediates are always zero-extended; shift amounts are taken from
    // B[5:0] by the ALU itself, so no clamping happens here.
    function automatic logic [DATA_W-1:0] zext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){1'b0}}, imm};
    endfunction

endpackage

// File: rtl/regfile_operand_stage_regfile.sv
// 32x64 register file with X31 hard-wired to zero, two combinational read
// ports and a write-through bypass so a same-cycle write-back is visible.
module regfile_32x64
    import regfile_operand_stage_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic [IDX_W-1:0]  rd_addr_a,
    input  logic [IDX_W-1:0]  rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem [NREGS];

    // Storage array; writes aimed at the zero register are discarded.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && (wr_addr != ZERO_IDX)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port A: zero register, then bypass from the write port, then array.
    always_comb begin
        rd_data_a = mem[rd_addr_a];
        if (rd_addr_a == ZERO_IDX) begin
            rd_data_a = '0;
        end else if (wr_en && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end
    end

    // Read port B: same priority as port A.
    always_comb begin
        rd_data_b = mem[rd_addr_b];
        if (rd_addr_b == ZERO_IDX) begin
            rd_data_b = '0;
        end else if (wr_en && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end
    end

endmodule

// File: rtl/regfile_operand_stage.sv
// Issue stage in front of the LEGv8 ALU: reads operands, stalls on RAW
// hazards via a busy scoreboard, and presents registered operands through
// a valid/ready handshake. Also holds the architectural NZCV flags.
module regfile_operand_stage
    import regfile_operand_stage_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  in_rn,
    input  logic [IDX_W-1:0]  in_rm,
    input  logic              in_use_imm,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [FS_W-1:0]   in_fs,
    input  logic              in_c0,
    input  logic [IDX_W-1:0]  in_rd,
    input  logic              in_wr_en,
    input  logic              in_set_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [FS_W-1:0]   out_fs,
    output logic              out_c0,
    output logic [IDX_W-1:0]  out_rd,
    output logic              out_wr_en,
    output logic              out_set_flags,
    input  logic              wb_en,
    input  logic [IDX_W-1:0]  wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_flags_en,
    input  logic [3:0]        wb_flags,
    output logic [3:0]        flags
);

    logic [DATA_W-1:0] rn_data;
    logic [DATA_W-1:0] rm_data;
    logic [DATA_W-1:0] b_sel;
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_next;
    logic              bypass_rn;
    logic              bypass_rm;
    logic              hazard_rn;
    logic              hazard_rm;
    logic              hazard;
    logic              accept;

    regfile_32x64 u_regfile (
        .clock     (clock),
        .reset_n   (reset_n),
        .rd_addr_a (in_rn),
        .rd_addr_b (in_rm),
        .rd_data_a (rn_data),
        .rd_data_b (rm_data),
        .wr_en     (wb_en),
        .wr_addr   (wb_addr),
        .wr_data   (wb_data)
    );

    // A busy source is fine if its value arrives on the write-back port this cycle.
    always_comb begin
        bypass_rn = wb_en && (wb_addr == in_rn) && (in_rn != ZERO_IDX);
        bypass_rm = wb_en && (wb_addr == in_rm) && (in_rm != ZERO_IDX);
        hazard_rn = busy[in_rn] && !bypass_rn;
        hazard_rm = !in_use_imm && busy[in_rm] && !bypass_rm;
        hazard    = hazard_rn || hazard_rm;
        in_ready  = !hazard && (!out_valid || out_ready);
        accept    = in_valid && in_ready;
        b_sel     = in_use_imm ? zext_imm(in_imm) : rm_data;
    end

    // Scoreboard update: clear on write-back first so a same-index set wins.
    always_comb begin
        busy_next = busy;
        if (wb_en) begin
            busy_next[wb_addr] = 1'b0;
        end
        if (accept && in_wr_en && (in_rd != ZERO_IDX)) begin
            busy_next[in_rd] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Output stage: load on accept, hold under backpressure, drop valid once consumed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid     <= 1'b0;
            out_a         <= '0;
            out_b         <= '0;
            out_fs        <= '0;
            out_c0        <= 1'b0;
            out_rd        <= '0;
            out_wr_en     <= 1'b0;
            out_set_flags <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_a         <= rn_data;
            out_b         <= b_sel;
            out_fs        <= in_fs;
            out_c0        <= in_c0;
            out_rd        <= in_rd;
            out_wr_en     <= in_wr_en;
            out_set_flags <= in_set_flags;
        end else if (out_ready) begin
            out_valid     <= 1'b0;
        end
    end

    // Architectural NZCV, loaded from the ALU status on write-back.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            flags <= 4'b0000;
        end else if (wb_flags_en) begin
            flags <= wb_flags;
        end
    end

endmodule
